// File: rtl/tsp_instr_pkg.sv
// Shared types and default constants for the loadable multi-channel instruction store.
package tsp_instr_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } istore_state_e;

  localparam int INSTR_W_DEFAULT = 32;

  typedef logic [INSTR_W_DEFAULT-1:0] instr_t;

  localparam instr_t NOP_WORD_DEFAULT  = '0;
  localparam instr_t RST_INSTR_DEFAULT = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req, priority pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  // Scan upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant = '0;
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/instr_store_mc.sv
// Loadable instruction store: sequential program loader, round-robin shared read port, end-of-program flag.
// Load beats transfer on load_valid & load_ready; fetches transfer on req_valid[c] & req_ready[c], response one cycle later.
module instr_store_mc
  import tsp_instr_pkg::*;
#(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 10,
  parameter int                     NUM_CH      = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(NOP_WORD_DEFAULT),
  parameter logic [INSTR_WIDTH-1:0] RST_INSTR   = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [INSTR_WIDTH-1:0]       load_data,
  input  logic                         load_last,
  output logic                         prog_ready,
  output logic [ADDR_WIDTH:0]          prog_len,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            rsp_valid,
  output logic [INSTR_WIDTH-1:0]       rsp_instr,
  output logic                         rsp_end,
  output logic [1:0]                   dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  istore_state_e           state_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]     prog_len_q;
  logic [INSTR_WIDTH-1:0]  mem [DEPTH];
  logic [INSTR_WIDTH-1:0]  rd_data_q;
  logic [NUM_CH-1:0]       rsp_valid_q;
  logic                    in_range_q;
  logic                    rsp_seen_q;
  logic                    accept;
  logic                    fetch_en;
  logic [NUM_CH-1:0]       grant;
  logic [ADDR_WIDTH-1:0]   sel_addr;

  assign load_ready = (state_q == LOAD) && !load_start;
  assign accept     = load_valid && load_ready;
  assign fetch_en   = (state_q == RUN) && !load_start;
  assign prog_ready = (state_q == RUN);
  assign prog_len   = prog_len_q;
  assign req_ready  = grant;
  assign dbg_state  = state_q;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid & {NUM_CH{fetch_en}}),
    .advance (|grant),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) sel_addr = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
    end else if (load_start) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
    end else if (accept) begin
      wr_ptr_q   <= wr_ptr_q + 1'b1;
      prog_len_q <= {1'b0, wr_ptr_q} + 1'b1;
      // The top address is an implicit last beat: the store is full.
      if (load_last || (wr_ptr_q == '1)) state_q <= RUN;
    end
  end

  // Memory has no reset so it maps onto block RAM; prog_len masks stale words.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr_q] <= load_data;
    if (|grant) rd_data_q <= mem[sel_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      in_range_q  <= 1'b0;
      rsp_seen_q  <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      if (|grant) begin
        in_range_q <= ({1'b0, sel_addr} < prog_len_q);
        rsp_seen_q <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = !rsp_seen_q ? RST_INSTR : (in_range_q ? rd_data_q : NOP_WORD);
  assign rsp_end   = (|rsp_valid_q) && (!in_range_q || (rd_data_q == NOP_WORD));

endmodule
